// File: rtl/zero_pkg.sv
// Shared definitions for the zero VM datapath and the array scan engine.
// Holds the heap element width, the per-array area size and the scan mode/state encodings
// so the VM and the scan unit always agree on them.
package zero_pkg;

  localparam int unsigned MemoryElementWidth = 12;
  localparam int unsigned NArea              = 10;

  typedef logic [MemoryElementWidth-1:0] elem_t;

  typedef enum logic [1:0] {
    COUNT_GREATER = 2'd0,
    COUNT_LESS    = 2'd1,
    COUNT_EQUAL   = 2'd2,
    INDEX_EQUAL   = 2'd3
  } scan_mode_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SIZE   = 2'd1,
    SCAN   = 2'd2,
    FINISH = 2'd3
  } scan_state_t;

endpackage

// File: rtl/array_scan_unit_if.sv
// Request/memory bundle between the VM (master) and the array scan unit (slave).
//   start/mode/array/key    : request from the VM
//   size_rd/size_addr/data  : arraySizes read port (data valid the cycle after size_rd)
//   heap_rd/heap_addr/data  : heap read port (data valid the cycle after heap_rd)
//   busy/done/result/err    : status and answer back to the VM
interface array_scan_unit_if
  import zero_pkg::*;
#(
  parameter int unsigned HeapAddrWidth = $clog2(2000 * NArea)
);

  logic                     start;
  logic [1:0]               mode;
  elem_t                    array;
  elem_t                    key;
  logic                     size_rd;
  elem_t                    size_addr;
  elem_t                    size_data;
  logic                     heap_rd;
  logic [HeapAddrWidth-1:0] heap_addr;
  elem_t                    heap_data;
  logic                     busy;
  logic                     done;
  elem_t                    result;
  logic                     err;

  modport master (
    output start, mode, array, key, size_data, heap_data,
    input  size_rd, size_addr, heap_rd, heap_addr, busy, done, result, err
  );

  modport slave (
    input  start, mode, array, key, size_data, heap_data,
    output size_rd, size_addr, heap_rd, heap_addr, busy, done, result, err
  );

endinterface

// File: rtl/array_scan_compare.sv
// Element/key comparator for the array scan engine. Keeps the mode decode out of the FSM.
//   mode_i    : scan mode
//   element_i : heap element being examined
//   key_i     : comparison key
//   match_o   : element satisfies the mode's predicate (unsigned compare)
module array_scan_compare
  import zero_pkg::*;
(
  input  scan_mode_t mode_i,
  input  elem_t      element_i,
  input  elem_t      key_i,
  output logic       match_o
);

  always_comb begin
    match_o = 1'b0;
    unique case (mode_i)
      COUNT_GREATER:            match_o = (element_i > key_i);
      COUNT_LESS:               match_o = (element_i < key_i);
      COUNT_EQUAL, INDEX_EQUAL: match_o = (element_i == key_i);
    endcase
  end

endmodule

// File: rtl/array_scan_unit.sv
// Multi-cycle engine for arrayCountGreater/Less/Equal and arrayIndex.
// Reads the array size, then streams up to NArea heap elements one per cycle, returning a count
// or a 1-based index.
//   clock, reset : single clock, synchronous active-high reset
//   bus (slave)  : request, arraySizes/heap read ports and status (see array_scan_unit_if)
module array_scan_unit
  import zero_pkg::*;
#(
  parameter int unsigned NArrays       = 2000,
  parameter int unsigned HeapAddrWidth = $clog2(NArrays * NArea)
) (
  input logic              clock,
  input logic              reset,
  array_scan_unit_if.slave bus
);

  scan_state_t              state_q, state_d;
  scan_mode_t               mode_q, mode_d;
  elem_t                    array_q, array_d;
  elem_t                    key_q, key_d;
  elem_t                    n_q, n_d, n_cur;
  elem_t                    rd_idx_q, rd_idx_d;
  elem_t                    cmp_idx_q, cmp_idx_d;
  elem_t                    count_q, count_d;
  elem_t                    result_q, result_d;
  logic                     err_q, err_d;
  logic                     vld_q;
  logic [HeapAddrWidth-1:0] base_q, base_d;
  logic                     match, hit;
  logic                     size_rd, heap_rd, busy, done;

  array_scan_compare u_compare (
    .mode_i    (mode_q),
    .element_i (bus.heap_data),
    .key_i     (key_q),
    .match_o   (match)
  );

  // Size arrives during the first SCAN cycle, which is the only SCAN cycle with no read issued yet.
  always_comb begin
    if (rd_idx_q == '0) begin
      n_cur = (bus.size_data > elem_t'(NArea)) ? elem_t'(NArea) : bus.size_data;
    end else begin
      n_cur = n_q;
    end
  end

  // vld_q marks the cycle in which the element for index cmp_idx_q is on heap_data.
  assign hit = vld_q & match;

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    array_d   = array_q;
    key_d     = key_q;
    n_d       = n_q;
    rd_idx_d  = rd_idx_q;
    cmp_idx_d = cmp_idx_q;
    count_d   = count_q;
    result_d  = result_q;
    err_d     = err_q;
    base_d    = base_q;
    size_rd   = 1'b0;
    heap_rd   = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          mode_d    = scan_mode_t'(bus.mode);
          array_d   = bus.array;
          key_d     = bus.key;
          base_d    = HeapAddrWidth'(bus.array) * HeapAddrWidth'(NArea);
          count_d   = '0;
          rd_idx_d  = '0;
          cmp_idx_d = '0;
          if (32'(bus.array) >= NArrays) begin
            result_d = '0;
            err_d    = 1'b1;
            state_d  = FINISH;
          end else begin
            state_d = SIZE;
          end
        end
      end

      SIZE: begin
        busy    = 1'b1;
        size_rd = 1'b1;
        state_d = SCAN;
      end

      SCAN: begin
        busy = 1'b1;
        n_d  = n_cur;
        if (vld_q) begin
          cmp_idx_d = cmp_idx_q + elem_t'(1);
        end
        if ((mode_q == INDEX_EQUAL) && hit) begin
          // Stop issuing reads; any read already in flight is dropped.
          result_d = cmp_idx_q + elem_t'(1);
          err_d    = 1'b0;
          state_d  = FINISH;
        end else begin
          if ((mode_q != INDEX_EQUAL) && hit) begin
            count_d = count_q + elem_t'(1);
          end
          if (rd_idx_q < n_cur) begin
            heap_rd  = 1'b1;
            rd_idx_d = rd_idx_q + elem_t'(1);
          end
          if (cmp_idx_d == n_cur) begin
            result_d = (mode_q == INDEX_EQUAL) ? '0 : count_d;
            err_d    = 1'b0;
            state_d  = FINISH;
          end
        end
      end

      FINISH: begin
        done    = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      mode_q    <= COUNT_GREATER;
      array_q   <= '0;
      key_q     <= '0;
      n_q       <= '0;
      rd_idx_q  <= '0;
      cmp_idx_q <= '0;
      count_q   <= '0;
      result_q  <= '0;
      err_q     <= 1'b0;
      vld_q     <= 1'b0;
      base_q    <= '0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      array_q   <= array_d;
      key_q     <= key_d;
      n_q       <= n_d;
      rd_idx_q  <= rd_idx_d;
      cmp_idx_q <= cmp_idx_d;
      count_q   <= count_d;
      result_q  <= result_d;
      err_q     <= err_d;
      vld_q     <= heap_rd;
      base_q    <= base_d;
    end
  end

  assign bus.size_rd   = size_rd;
  assign bus.size_addr = array_q;
  assign bus.heap_rd   = heap_rd;
  assign bus.heap_addr = base_q + HeapAddrWidth'(rd_idx_q);
  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.result    = result_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_array_scan_unit.sv
// Bench for array_scan_unit: directed test-plan cases plus randomized operations checked
// against a plain loop-over-the-array reference model.
module tb_array_scan_unit;
  import zero_pkg::*;

  localparam int unsigned NArr = 2000;
  localparam int unsigned HAW  = $clog2(NArr * NArea);

  logic clock;
  logic reset;

  array_scan_unit_if #(.HeapAddrWidth(HAW)) bus ();

  array_scan_unit #(
    .NArrays       (NArr),
    .HeapAddrWidth (HAW)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  logic [11:0] sizes_mem [NArr];
  logic [11:0] heap_mem  [NArr * NArea];

  // Memories with one-cycle read latency.
  always @(posedge clock) begin
    if (bus.size_rd) bus.size_data <= sizes_mem[bus.size_addr];
    if (bus.heap_rd) bus.heap_data <= heap_mem[bus.heap_addr];
  end

  int rd_q[$];
  int size_cnt;
  int size_addr_last;
  int n_checks;
  int n_fail;

  always @(negedge clock) begin
    if (bus.heap_rd === 1'b1) rd_q.push_back(int'(bus.heap_addr));
    if (bus.size_rd === 1'b1) begin
      size_cnt++;
      size_addr_last = int'(bus.size_addr);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: walk the array area as the instruction semantics describe.
  function automatic void model(input int arr, input int key, input int mode,
                                output int res, output int er, output int lat, output int nrd);
    int n;
    res = 0; er = 0; nrd = 0; lat = 1;
    if (arr >= int'(NArr)) begin
      er = 1;
      return;
    end
    n   = (int'(sizes_mem[arr]) > int'(NArea)) ? int'(NArea) : int'(sizes_mem[arr]);
    lat = 3 + n;
    nrd = n;
    for (int i = 0; i < n; i++) begin
      int e;
      e = int'(heap_mem[arr * int'(NArea) + i]);
      case (mode)
        0: if (e > key) res++;
        1: if (e < key) res++;
        2: if (e == key) res++;
        default: if (e == key) begin
          res = i + 1;
          lat = 4 + i;
          nrd = i + 1;
          return;
        end
      endcase
    end
  endfunction

  task automatic do_op(input string tag, input int arr, input int key, input int mode,
                       input bit disturb);
    int  exp_res, exp_err, exp_lat, exp_rd;
    int  lat;
    bit  seen;
    model(arr, key, mode, exp_res, exp_err, exp_lat, exp_rd);
    @(negedge clock);
    bus.start = 1'b1;
    bus.array = 12'(arr);
    bus.key   = 12'(key);
    bus.mode  = 2'(mode);
    rd_q.delete();
    size_cnt       = 0;
    size_addr_last = -1;
    @(negedge clock);
    bus.start = 1'b0;
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 64) begin
      lat++;
      if (bus.done === 1'b1) begin
        seen = 1'b1;
      end else begin
        if (disturb) begin
          bus.start = 1'b1;
          bus.array = 12'($urandom_range(0, NArr - 1));
          bus.key   = 12'($urandom_range(0, 4095));
          bus.mode  = 2'($urandom_range(0, 3));
        end
        @(negedge clock);
      end
    end
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_result"}, 32'(bus.result), exp_res);
    check({tag, "_err"}, 32'(bus.err), exp_err);
    check({tag, "_busy_at_done"}, 32'(bus.busy), 32'd0);
    check({tag, "_heap_reads"}, rd_q.size(), exp_rd);
    for (int i = 0; i < rd_q.size() && i < exp_rd; i++) begin
      check({tag, "_heap_addr"}, rd_q[i], arr * int'(NArea) + i);
    end
    check({tag, "_size_reads"}, size_cnt, (exp_err != 0) ? 0 : 1);
    if (exp_err == 0) check({tag, "_size_addr"}, size_addr_last, arr);
    if (disturb) begin
      // start is still high across the edge that ends the done cycle: must be ignored.
      @(negedge clock);
      bus.start = 1'b0;
      check({tag, "_start_at_done_ignored"}, 32'(bus.busy), 32'd0);
      check({tag, "_result_held"}, 32'(bus.result), exp_res);
    end
  endtask

  initial begin
    int busy_cnt, done_cnt;
    n_checks  = 0;
    n_fail    = 0;
    size_cnt  = 0;
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.mode  = 2'd0;
    bus.array = '0;
    bus.key   = '0;
    bus.size_data = '0;
    bus.heap_data = '0;
    for (int i = 0; i < int'(NArr); i++) sizes_mem[i] = '0;
    for (int i = 0; i < int'(NArr * NArea); i++) heap_mem[i] = '0;
    sizes_mem[0] = 12'd3;
    heap_mem[0]  = 12'd10;
    heap_mem[1]  = 12'd20;
    heap_mem[2]  = 12'd30;
    heap_mem[3]  = 12'd20;  // beyond size: must never be counted

    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_result", 32'(bus.result), 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);
    check("rst_size_rd", 32'(bus.size_rd), 32'd0);
    check("rst_heap_rd", 32'(bus.heap_rd), 32'd0);

    do_op("cg15", 0, 15, 0, 1'b0);
    do_op("cl25", 0, 25, 1, 1'b0);
    do_op("ce20", 0, 20, 2, 1'b0);
    do_op("ce99", 0, 99, 2, 1'b0);
    do_op("ix10", 0, 10, 3, 1'b0);
    do_op("ix30", 0, 30, 3, 1'b0);
    do_op("ix25", 0, 25, 3, 1'b0);

    sizes_mem[5] = 12'd0;
    do_op("a5_empty", 5, 0, 0, 1'b0);
    sizes_mem[5] = 12'd15;
    for (int i = 50; i < 60; i++) heap_mem[i] = 12'd40;
    for (int i = 60; i < 65; i++) heap_mem[i] = 12'd99;
    do_op("a5_clamp", 5, 0, 0, 1'b0);

    do_op("oob", int'(NArr), 7, 2, 1'b0);
    do_op("busy_start", 0, 15, 0, 1'b1);

    // Reset in the middle of a 3-element scan.
    @(negedge clock);
    bus.start = 1'b1;
    bus.array = 12'd0;
    bus.key   = 12'd15;
    bus.mode  = 2'd0;
    @(negedge clock);
    bus.start = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    rd_q.delete();
    size_cnt = 0;
    busy_cnt = 0;
    done_cnt = 0;
    repeat (8) begin
      @(negedge clock);
      if (bus.busy !== 1'b0) busy_cnt++;
      if (bus.done !== 1'b0) done_cnt++;
    end
    check("rstmid_busy", busy_cnt, 0);
    check("rstmid_done", done_cnt, 0);
    check("rstmid_heap_rd", rd_q.size(), 0);
    check("rstmid_size_rd", size_cnt, 0);
    check("rstmid_result", 32'(bus.result), 32'd0);
    do_op("after_rst", 0, 15, 0, 1'b0);

    for (int r = 0; r < 40; r++) begin
      int arr;
      arr = (r % 8 == 7) ? int'($urandom_range(NArr, 4095)) : int'($urandom_range(0, NArr - 1));
      if (arr < int'(NArr)) begin
        sizes_mem[arr] = 12'($urandom_range(0, 14));
        for (int i = 0; i < int'(NArea); i++) begin
          heap_mem[arr * int'(NArea) + i] =
            ($urandom_range(0, 9) == 0) ? 12'hfff : 12'($urandom_range(0, 7));
        end
      end
      do_op($sformatf("rand%0d", r), arr, int'($urandom_range(0, 8)),
            int'($urandom_range(0, 3)), (r % 10) == 3);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/array_scan_unit.md
Name: array_scan_unit

Overview:
- Multi-cycle sequential engine for the zero VM's array-search instructions: arrayCountGreater, arrayCountLess, arrayCountEqual and arrayIndex.
- Given an array number and a key, it reads the array's current size and then streams that array's NArea-element heap area one element per cycle.
- It returns a count or a 1-based index.
- It replaces the single-cycle loop-over-NArea evaluation with a parametrised, pipelined scan that the fpga VM instantiates once and shares across instructions.

Parameters:
- MemoryElementWidth, 12, width of heap elements, keys, sizes and results.
- NArea, 10, elements per array area on the heap; must be < 2**MemoryElementWidth.
- NArrays, 2000, number of arrays; array n occupies heap[n*NArea .. n*NArea+NArea-1].
- HeapAddrWidth, $clog2(NArrays*NArea), heap address width.

Ports:
- clock  in  1  single clock.
- reset  in  1  synchronous, active-high.
- start  in  1  request pulse; sampled only in IDLE.
- mode  in  2  0=COUNT_GREATER, 1=COUNT_LESS, 2=COUNT_EQUAL, 3=INDEX_EQUAL.
- array  in  MemoryElementWidth  array number.
- key  in  MemoryElementWidth  comparison value.
- size_rd  out  1  read strobe to the arraySizes memory.
- size_addr  out  MemoryElementWidth  arraySizes index.
- size_data  in  MemoryElementWidth  size; valid the cycle after size_rd.
- heap_rd  out  1  heap read strobe.
- heap_addr  out  HeapAddrWidth  heap address.
- heap_data  in  MemoryElementWidth  element; valid the cycle after heap_rd.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle completion pulse.
- result  out  MemoryElementWidth  count or index; held until the next accepted start.
- err  out  1  array out of range; valid with done and held with result.

Behaviour:
- Reset values: busy=0, done=0, result=0, err=0, size_rd=0, heap_rd=0, state=IDLE.
- Reset asserted mid-scan forces IDLE on the next edge. No read strobe is issued afterwards, and no done pulse is issued for the aborted request.
- States: IDLE -> SIZE -> SCAN -> FINISH -> IDLE.
- IDLE: on start at edge T, latch mode, array and key; clear the counter; set busy.
  - If array >= NArrays, go directly to FINISH with err=1 and result=0; done is pulsed at T+1 and no reads are issued.
- SIZE (cycle T+1): size_rd=1, size_addr=array.
- SCAN (from T+2):
  - Latch n = min(size_data, NArea); values above NArea are clamped.
  - Issue heap_rd with heap_addr=array*NArea+i for i=0..n-1 on consecutive cycles T+2..T+1+n.
  - The element for index i returns at T+3+i and is compared the same cycle.
  - Comparisons are unsigned, full MemoryElementWidth.
- COUNT modes: the counter increments when element>key, element<key or element==key respectively. result=count. done pulses at T+3+n (T+3 when n=0).
- INDEX_EQUAL: at the first element equal to key (index m), result=m+1. No further heap_rd is issued after the match is seen; reads already issued are discarded. done pulses at T+4+m.
  - If no element matches, result=0 and done pulses at T+3+n.
- FINISH: done=1 for exactly one cycle, busy drops in the same cycle, and the next state is IDLE.
  - A start coincident with done is ignored; a new start is accepted from the cycle after done.
- start while busy is ignored; latched operands are not disturbed.
- The counter cannot overflow, because n <= NArea < 2**MemoryElementWidth.
- A key or array change on the input ports while busy has no effect.

Decomposition:
- Shared package zero_pkg:
  - scan_mode_t enum (COUNT_GREATER, COUNT_LESS, COUNT_EQUAL, INDEX_EQUAL).
  - scan_state_t enum (IDLE, SIZE, SCAN, FINISH).
  - Constants MemoryElementWidth and NArea, so the VM and this block agree.
- One sub-module, array_scan_compare: combinational, takes mode, element and key, and returns a match bit. It keeps the mode decode out of the FSM.

Test Plan:
- Array 0 = [10,20,30] (size 3), mode COUNT_GREATER, key 15, start at T -> result=2, err=0, done at T+6, 3 heap reads at addresses 0,1,2.
- Same array: COUNT_LESS key 25 -> 2; COUNT_EQUAL key 20 -> 1; COUNT_EQUAL key 99 -> 0.
- INDEX_EQUAL key 10 -> result=1, done at T+4, exactly 1 heap_rd. INDEX_EQUAL key 30 -> 3, done at T+6. INDEX_EQUAL key 25 -> 0, done at T+6.
- Array 5 with size 0 -> result 0, done at T+3, no heap_rd. Array 5 with size 15 and all elements 40, COUNT_GREATER key 0 -> result 10; heap addresses 50..59 only.
- array=NArrays -> err=1, result=0, done at T+1, no size_rd or heap_rd. A second start during a busy scan -> ignored, and the first result is unchanged.
- Reset asserted at T+4 of a 3-element scan -> busy=0 and done=0 thereafter, no further strobes. A fresh start afterwards completes normally with result=2.
